// File: rtl/seg7_serial_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_serial_decoder
// Description : Receive-side partner of the hex-to-7-segment encoder tile.
//               An 8-bit segment pattern arrives LSB first on a bit-banged
//               strobe interface. The pattern is checked against the 16
//               legal glyphs and the letter flag. The recovered nibble is
//               registered, and a saturating 4-bit error count is kept.
//
// Ports (TinyTapeout 8-in / 8-out pad interface)
//   io_in[0]    clk       sole clock, rising edge
//   io_in[1]    rst       synchronous, active-high reset
//   io_in[2]    sdata     serial pattern bit
//   io_in[3]    sstb      bit strobe; its rising edge shifts in sdata
//   io_in[4]    frame     high while a frame is in progress
//   io_in[5]    show_cnt  io_out[3:0] shows 0 = nibble, 1 = error count
//   io_in[7:6]  unused
//   io_out[3:0] decoded nibble or error count
//   io_out[4]   done      a frame was decoded; cleared by the next first bit
//   io_out[5]   err       the last decoded frame was illegal
//   io_out[6]   busy      1..7 bits of the current frame received
//   io_out[7]   letter    bit 7 of the last decoded frame
//
// Build option
//   SEG7_RX_SYNC2_EN : when defined, io_in[4:2] pass through two flops
//                      (asynchronous drivers). When it is not defined, they
//                      pass through one flop, and the driver must be
//                      synchronous to clk.
//
// Revision    : 1.0 - initial release
// ============================================================================

module seg7_serial_decoder (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

`ifdef SEG7_RX_SYNC2_EN
    localparam int unsigned C_SYNC_STAGES = 2;
`else
    localparam int unsigned C_SYNC_STAGES = 1;
`endif

    // ------------------------------------------------------------------
    // Pad unpacking
    // ------------------------------------------------------------------
    logic clk;
    logic rst;
    logic w_show_cnt;
    logic w_unused_pads;

    assign clk           = io_in[0];
    assign rst           = io_in[1];
    assign w_show_cnt    = io_in[5];
    assign w_unused_pads = ^io_in[7:6];

    // ------------------------------------------------------------------
    // Input conditioning
    // w_*_pre is the value loaded into the final sync stage on each edge.
    // w_pre_valid is high once that value reflects the pad rather than
    // reset contents.
    // ------------------------------------------------------------------
    logic w_sdata_pre;
    logic w_sstb_pre;
    logic w_frame_pre;
    logic w_pre_valid;

    generate
        if (C_SYNC_STAGES == 2) begin : g_sync2
            logic r_sdata_m;
            logic r_sstb_m;
            logic r_frame_m;
            logic r_pre_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sdata_m   <= 1'b0;
                    r_sstb_m    <= 1'b0;
                    r_frame_m   <= 1'b0;
                    r_pre_valid <= 1'b0;
                end else begin
                    r_sdata_m   <= io_in[2];
                    r_sstb_m    <= io_in[3];
                    r_frame_m   <= io_in[4];
                    r_pre_valid <= 1'b1;
                end
            end

            assign w_sdata_pre = r_sdata_m;
            assign w_sstb_pre  = r_sstb_m;
            assign w_frame_pre = r_frame_m;
            assign w_pre_valid = r_pre_valid;
        end else begin : g_sync1
            assign w_sdata_pre = io_in[2];
            assign w_sstb_pre  = io_in[3];
            assign w_frame_pre = io_in[4];
            assign w_pre_valid = 1'b1;
        end
    endgenerate

    logic r_sdata_s;
    logic r_sstb_s;
    logic r_frame_s;
    logic r_sstb_d;
    // r_armed is set once a genuine low level of sstb has been seen after
    // reset. Without it, the zeroed edge flop would turn a strobe held high
    // through reset into a phantom rising edge.
    logic r_armed;
    logic w_rise;

    assign w_rise = r_sstb_s & ~r_sstb_d & r_armed;

    // ------------------------------------------------------------------
    // Receive and decode state
    // ------------------------------------------------------------------
    logic [7:0] r_shreg;
    logic [2:0] r_bitcnt;   // bits received modulo 8
    logic       r_full;     // all 8 bits are in; holds until frame_s drops
    logic       r_dec_pend; // the 8th bit landed on the previous edge
    logic [3:0] r_nibble;
    logic       r_letter;
    logic       r_done;
    logic       r_err;
    logic [3:0] r_err_cnt;

    logic       w_shift;
    logic       w_busy;

    assign w_shift = w_rise & r_frame_s & ~r_full;
    assign w_busy  = (r_bitcnt != 3'd0) & ~r_full;

    // ------------------------------------------------------------------
    // Glyph lookup: combinational from the shift register, registered only
    // by the decode edge.
    // ------------------------------------------------------------------
    logic       w_match;
    logic [3:0] w_index;
    logic       w_letter_ok;
    logic       w_bad;

    always_comb begin
        w_match = 1'b1;
        w_index = 4'h0;
        case (r_shreg[6:0])
            7'h3F:   w_index = 4'h0;
            7'h06:   w_index = 4'h1;
            7'h5B:   w_index = 4'h2;
            7'h4F:   w_index = 4'h3;
            7'h66:   w_index = 4'h4;
            7'h6D:   w_index = 4'h5;
            7'h7D:   w_index = 4'h6;
            7'h07:   w_index = 4'h7;
            7'h7F:   w_index = 4'h8;
            7'h6F:   w_index = 4'h9;
            7'h77:   w_index = 4'hA;
            7'h7C:   w_index = 4'hB;
            7'h39:   w_index = 4'hC;
            7'h5E:   w_index = 4'hD;
            7'h79:   w_index = 4'hE;
            7'h71:   w_index = 4'hF;
            default: w_match = 1'b0;
        endcase
    end

    assign w_letter_ok = (r_shreg[7] == (w_index >= 4'hA));
    assign w_bad       = ~w_match | ~w_letter_ok;

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sdata_s  <= 1'b0;
            r_sstb_s   <= 1'b0;
            r_frame_s  <= 1'b0;
            r_sstb_d   <= 1'b0;
            r_armed    <= 1'b0;
            r_shreg    <= 8'h00;
            r_bitcnt   <= 3'd0;
            r_full     <= 1'b0;
            r_dec_pend <= 1'b0;
            r_nibble   <= 4'h0;
            r_letter   <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_cnt  <= 4'h0;
        end else begin
            r_sdata_s <= w_sdata_pre;
            r_sstb_s  <= w_sstb_pre;
            r_frame_s <= w_frame_pre;
            r_sstb_d  <= r_sstb_s;
            // Arming happens on the same edge that the low level reaches
            // r_sstb_s, so it can never create a rise of its own.
            r_armed   <= r_armed | (~w_sstb_pre & w_pre_valid);

            // The frame gate wins over a simultaneous strobe rise.
            if (!r_frame_s) begin
                r_bitcnt <= 3'd0;
                r_full   <= 1'b0;
            end else if (w_shift) begin
                r_shreg  <= {r_sdata_s, r_shreg[7:1]};
                r_bitcnt <= r_bitcnt + 3'd1;
                if (r_bitcnt == 3'd7) begin
                    r_full <= 1'b1;
                end
                if (r_bitcnt == 3'd0 && !r_full) begin
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
                end
            end

            r_dec_pend <= w_shift & (r_bitcnt == 3'd7);

            // A full frame is decoded even if frame_s has already dropped.
            // Only partial frames are discarded.
            if (r_dec_pend) begin
                r_done <= 1'b1;
                r_err  <= w_bad;
                if (w_match) begin
                    r_nibble <= w_index;
                    r_letter <= r_shreg[7];
                end
                if (w_bad && r_err_cnt != 4'hF) begin
                    r_err_cnt <= r_err_cnt + 4'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output packing. show_cnt only steers a display mux, so it is used
    // unregistered.
    // ------------------------------------------------------------------
    assign io_out = {r_letter, w_busy, r_err, r_done,
                     (w_show_cnt ? r_err_cnt : r_nibble)};

endmodule

`default_nettype wire

// File: tb/tb_seg7_serial_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_serial_decoder
// Description : Directed self-checking bench for seg7_serial_decoder.
//               A glyph model pushes each frame's expected result onto a
//               scoreboard queue. That entry is popped and compared on the
//               exact decode edge.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_seg7_serial_decoder;

`ifdef SEG7_RX_SYNC2_EN
    localparam int S = 2;
`else
    localparam int S = 1;
`endif

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct packed {
        logic [3:0] nib;
        logic       letter;
        logic       err;
        logic [3:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       sdata;
    logic       sstb;
    logic       frame;
    logic       show_cnt;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    logic [3:0] m_nib;
    logic       m_let;
    logic       m_done;
    logic       m_err;
    logic [3:0] m_cnt;

    assign io_in = {2'b00, show_cnt, frame, sstb, sdata, rst, clk};

    always #5 clk = ~clk;

    seg7_serial_decoder dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] exp_out();
        return {m_let, 1'b0, m_err, m_done, (show_cnt ? m_cnt : m_nib)};
    endfunction

    function automatic void model_reset();
        m_nib = 4'h0; m_let = 1'b0; m_done = 1'b0; m_err = 1'b0; m_cnt = 4'h0;
    endfunction

    function automatic void model_push(input logic [7:0] v);
        logic       hit;
        logic [3:0] idx;
        logic       bad;
        exp_t       e;
        hit = 1'b0;
        idx = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (GLYPH[i] == v[6:0]) begin
                hit = 1'b1;
                idx = i[3:0];
            end
        end
        bad = !hit || (v[7] != (idx >= 4'hA));
        if (hit) begin
            m_nib = idx;
            m_let = v[7];
        end
        if (bad && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
        m_done = 1'b1;
        m_err  = bad;
        e.nib = m_nib; e.letter = m_let; e.err = bad; e.cnt = m_cnt;
        sb.push_back(e);
    endfunction

    // One strobe. first_chk verifies that done/err clear exactly on the
    // shift edge. last_chk verifies the decode lands exactly on edge S+2.
    task automatic strobe(input logic b, input logic first_chk,
                          input logic [1:0] pre_ed, input logic last_chk);
        exp_t e;
        @(negedge clk);
        sdata = b;
        sstb  = 1'b1;
        for (int k = 1; k <= S + 2; k++) begin
            @(posedge clk);
            #1;
            if (first_chk && k == S)
                chk("first_bit_before", {6'h00, io_out[5:4]}, {6'h00, pre_ed});
            if (first_chk && k == S + 1)
                chk("first_bit_clear", {6'h00, io_out[5:4]}, 8'h00);
            if (last_chk && k == S + 1)
                chk("decode_not_early", {7'h00, io_out[4]}, 8'h00);
            if (last_chk && k == S + 2) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL sb_underflow observed=empty expected=entry");
                end else begin
                    e = sb.pop_front();
                    chk("decode_out", io_out,
                        {e.letter, 1'b0, e.err, 1'b1, (show_cnt ? e.cnt : e.nib)});
                end
            end
        end
        @(negedge clk);
        sstb = 1'b0;
        repeat (S + 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] v, input logic extra9);
        @(negedge clk);
        frame = 1'b1;
        repeat (S) @(negedge clk);
        model_push(v);
        for (int i = 0; i < 8; i++) strobe(v[i], 1'b0, 2'b00, (i == 7));
        if (extra9) begin
            strobe(1'b1, 1'b0, 2'b00, 1'b0);
            chk("ninth_strobe_ignored", io_out, exp_out());
        end
        @(negedge clk);
        frame = 1'b0;
        repeat (S + 2) @(negedge clk);
        chk("after_frame", io_out, exp_out());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        rst = 1'b1; sstb = 1'b1; sdata = 1'b1; frame = 1'b1; show_cnt = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_out", io_out, 8'h00);

        // Strobe and frame stay high across the release: no shift may occur.
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("no_shift_after_reset", io_out, 8'h00);
        sstb = 1'b0;
        frame = 1'b0;
        repeat (S + 2) @(negedge clk);
        chk("idle_after_reset", io_out, 8'h00);

        send_frame(8'h3F, 1'b0);            // 0, legal
        send_frame(8'hF7, 1'b0);            // A, letter set
        send_frame(8'h86, 1'b0);            // 1, letter flag wrong
        show_cnt = 1'b1;
        #1;
        chk("count_after_86", {4'h0, io_out[3:0]}, {4'h0, m_cnt});
        show_cnt = 1'b0;
        #1;
        chk("nibble_after_86", {4'h0, io_out[3:0]}, 8'h01);

        send_frame(8'h00, 1'b0);            // no glyph: nibble holds

        // Partial frame of five bits, then abort.
        @(negedge clk);
        frame = 1'b1;
        repeat (S) @(negedge clk);
        strobe(1'b1, 1'b1, 2'b11, 1'b0);
        for (int i = 1; i < 5; i++) strobe(i[0], 1'b0, 2'b00, 1'b0);
        chk("busy_mid_frame", {7'h00, io_out[6]}, 8'h01);
        m_done = 1'b0;
        m_err  = 1'b0;
        @(negedge clk);
        frame = 1'b0;
        repeat (S + 2) @(negedge clk);
        chk("abort_no_change", io_out, exp_out());

        send_frame(8'h4F, 1'b1);            // 3, plus ignored 9th strobe

        // Saturation of the error counter.
        show_cnt = 1'b1;
        for (int i = 0; i < 17; i++) send_frame((i % 2 == 1) ? 8'h00 : 8'h86, 1'b0);
        chk("count_saturated", {4'h0, io_out[3:0]}, 8'h0F);

        // Reset in the middle of a frame.
        show_cnt = 1'b0;
        @(negedge clk);
        frame = 1'b1;
        repeat (S) @(negedge clk);
        for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0, 2'b00, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_frame_reset", io_out, 8'h00);
        model_reset();
        @(negedge clk);
        frame = 1'b0;
        rst = 1'b0;
        repeat (S + 2) @(negedge clk);
        send_frame(8'h06, 1'b0);            // 1, legal, counter restarted
        show_cnt = 1'b1;
        #1;
        chk("count_after_reset", {4'h0, io_out[3:0]}, 8'h00);

        chk("scoreboard_empty", sb.size() > 255 ? 8'hFF : 8'(sb.size()), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
